csr_trap_ctrl: RTL

//  Machine-mode CSR file and trap sequencer for the core's timer interrupt and mret.

---
 rtl/csr_trap_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file and timer-interrupt / mret trap sequencer.
// Drains the pipeline before redirecting fetch to the handler or back to mepc.
//
// state  | meaning
// IDLE   | normal execution, watching for mret or a pending timer interrupt
// FLUSH  | flush_req held until the pipeline reports drained
// ENTER  | excep pulse, fetch redirected to trap_pc
// RETURN | epc_taken pulse, fetch redirected to mepc
module csr_trap_ctrl #(
   parameter int               XLEN        = 32,
   parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tm_interupt,
   input  logic            is_mret,
   input  logic [XLEN-1:0] pc_cur,
   input  logic            csr_we,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            flush_req,
   input  logic            flush_ack,
   output logic            excep,
   output logic [XLEN-1:0] trap_pc,
   output logic            epc_taken,
   output logic [XLEN-1:0] epc
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MIP     = 12'h344;

   localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);
   localparam logic [XLEN-1:0] VEC_OFFSET  = XLEN'(28);
   localparam logic [XLEN-1:0] CAUSE_TIMER = {1'b1, {(XLEN-5){1'b0}}, 4'd7};

   typedef enum logic [1:0] {IDLE, FLUSH, ENTER, RETURN} state_t;

   state_t          state, state_nxt;
   logic            hw_trap, hw_ret;
   logic            mstatus_mie, mstatus_mpie, mie_mtie, mip_mtip;
   logic [XLEN-1:0] mepc, mcause, mtvec;
   logic            pending;
   logic [XLEN-1:0] trap_target;

   assign pending = mstatus_mie & mie_mtie & mip_mtip;

   // MODE 1 is vectored; reserved modes 2/3 fall back to direct
   assign trap_target = {mtvec[XLEN-1:2], 2'b00} +
                        ((mtvec[1:0] == 2'b01) ? VEC_OFFSET : '0);

   always_comb begin
      state_nxt = state;
      hw_trap   = 1'b0;
      hw_ret    = 1'b0;
      case (state)
         IDLE: begin
            if (is_mret) begin
               state_nxt = RETURN;
               hw_ret    = 1'b1;
            end else if (pending) begin
               state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (flush_ack) begin
               state_nxt = ENTER;
               hw_trap   = 1'b1;
            end
         end
         ENTER:   state_nxt = IDLE;
         RETURN:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         flush_req <= 1'b0;
         excep     <= 1'b0;
         trap_pc   <= '0;
         epc_taken <= 1'b0;
         epc       <= '0;
      end else begin
         state     <= state_nxt;
         flush_req <= (state_nxt == FLUSH);
         excep     <= hw_trap;
         trap_pc   <= hw_trap ? trap_target : '0;
         epc_taken <= hw_ret;
         epc       <= hw_ret ? mepc : '0;
      end
   end

   // Hardware trap/return updates take priority over a same-cycle CSR write
   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_mtie     <= 1'b0;
         mip_mtip     <= 1'b0;
         mepc         <= '0;
         mcause       <= '0;
         mtvec        <= MTVEC_RESET;
      end else begin
         mip_mtip <= tm_interupt;
         if (hw_trap) begin
            mepc         <= pc_cur & ALIGN_MASK;
            mcause       <= CAUSE_TIMER;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
         end else if (hw_ret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
         end
         if (csr_we) begin
            case (csr_addr)
               ADDR_MSTATUS: begin
                  if (!hw_trap && !hw_ret) begin
                     mstatus_mie  <= csr_wdata[3];
                     mstatus_mpie <= csr_wdata[7];
                  end
               end
               ADDR_MIE:    mie_mtie <= csr_wdata[7];
               ADDR_MEPC:   if (!hw_trap) mepc <= csr_wdata & ALIGN_MASK;
               ADDR_MCAUSE: if (!hw_trap) mcause <= csr_wdata;
               ADDR_MTVEC:  mtvec <= csr_wdata;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         ADDR_MSTATUS: begin
            csr_rdata[3] = mstatus_mie;
            csr_rdata[7] = mstatus_mpie;
         end
         ADDR_MIE:    csr_rdata[7] = mie_mtie;
         ADDR_MIP:    csr_rdata[7] = mip_mtip;
         ADDR_MEPC:   csr_rdata = mepc;
         ADDR_MCAUSE: csr_rdata = mcause;
         ADDR_MTVEC:  csr_rdata = mtvec;
         default:     csr_rdata = '0;
      endcase
   end

endmodule
